pc_call_stack: RTL and testbench

//   Parametrised program counter with a hardware call/return stack of DEPTH entries.

---
 rtl/pc_pkg.sv | 29 ++
 rtl/ret_stack.sv | 77 +++++++
 rtl/pc_call_stack.sv | 122 ++++++++++++
 tb/tb_pc_call_stack.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter / call stack block.
// Operation encoding produced by the top-level priority decoder lives here.
package pc_pkg;

    localparam int PC_ADDR_W_DEF = 11;
    localparam int PC_REL_W_DEF  = 10;
    localparam int PC_DEPTH_DEF  = 4;

    // Working width for sign extension; callers truncate to their own ADDR_W.
    localparam int SEXT_W = 32;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_LOAD,
        PC_CALL,
        PC_RET,
        PC_BRANCH,
        PC_INC
    } pc_op_t;

    // Sign-extend the low rel_w bits of rel to SEXT_W bits.
    function automatic logic [SEXT_W-1:0] sext_rel(input logic [SEXT_W-1:0] rel,
                                                   input int rel_w);
        logic signed [SEXT_W-1:0] t;
        t = signed'(rel << (SEXT_W - rel_w));
        return t >>> (SEXT_W - rel_w);
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address LIFO: DEPTH entries addressed by a modulo write pointer.
// A push when full overwrites the oldest entry; a pop when empty only raises a strobe.
module ret_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W_DEF,
    parameter int DEPTH  = PC_DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        push_data,
    output logic [ADDR_W-1:0]        top_data,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     ovf_stb,
    output logic                     unf_stb
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] FULL    = DW'(DEPTH);
    localparam logic [DW-1:0] D_ONE   = DW'(1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              full, empty;

    assign full  = (depth_q == FULL);
    assign empty = (depth_q == '0);

    // wr_ptr points at the next free slot, so the top is one below it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        depth_d  = depth_q;
        ovf_stb  = 1'b0;
        unf_stb  = 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + P_ONE;
            if (full) begin
                ovf_stb = 1'b1;
            end else begin
                depth_d = depth_q + D_ONE;
            end
        end else if (pop) begin
            if (empty) begin
                unf_stb = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q - P_ONE;
                depth_d  = depth_q - D_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            depth_q  <= depth_d;
        end
    end

    // Entry storage carries no reset; contents are meaningless while depth is 0.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign top_data = mem_q[wr_ptr_q - P_ONE];
    assign depth    = depth_q;

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with preload, relative branch, and a hardware call/return stack.
// Optional err_clr input for the sticky flags when PC_CALL_STACK_ERRCLR_EN is defined.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W_DEF,
    parameter int REL_W  = PC_REL_W_DEF,
    parameter int DEPTH  = PC_DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     stall,
    input  logic                     preload,
    input  logic [ADDR_W-1:0]        preload_addr,
    input  logic                     branch,
    input  logic                     jsr,
    input  logic                     ret,
    input  logic [REL_W-1:0]         rel_addr,
`ifdef PC_CALL_STACK_ERRCLR_EN
    input  logic                     err_clr,
`endif
    output logic [ADDR_W-1:0]        pc,
    output logic [ADDR_W-1:0]        incr_pc,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    pc_op_t                   op;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [ADDR_W-1:0]        incr_q, incr_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;
    logic signed [ADDR_W-1:0] rel_ext;
    logic [ADDR_W-1:0]        stk_top;
    logic [DW-1:0]            stk_depth;
    logic                     stk_ovf, stk_unf;
    logic                     flag_clr;

    assign rel_ext = signed'(ADDR_W'(sext_rel(SEXT_W'(rel_addr), REL_W)));

`ifdef PC_CALL_STACK_ERRCLR_EN
    assign flag_clr = err_clr;
`else
    assign flag_clr = 1'b0;
`endif

    always_comb begin
        op = PC_INC;
        if (stall) begin
            op = PC_HOLD;
        end else if (preload) begin
            op = PC_LOAD;
        end else if (jsr) begin
            op = PC_CALL;
        end else if (ret) begin
            op = PC_RET;
        end else if (branch) begin
            op = PC_BRANCH;
        end
    end

    ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ret_stack (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (op == PC_CALL),
        .pop       (op == PC_RET),
        .push_data (incr_q),
        .top_data  (stk_top),
        .depth     (stk_depth),
        .ovf_stb   (stk_ovf),
        .unf_stb   (stk_unf)
    );

    // A ret on an empty stack degrades to a plain increment.
    always_comb begin
        pc_d = pc_q;
        case (op)
            PC_HOLD:   pc_d = pc_q;
            PC_LOAD:   pc_d = preload_addr;
            PC_CALL:   pc_d = pc_q + rel_ext;
            PC_BRANCH: pc_d = pc_q + rel_ext;
            PC_RET:    pc_d = (stk_depth != '0) ? stk_top : incr_q;
            PC_INC:    pc_d = incr_q;
            default:   pc_d = pc_q;
        endcase
        incr_d = (op == PC_HOLD) ? incr_q : pc_d + A_ONE;
    end

    // A fresh error in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = flag_clr ? stk_ovf : (ovf_q | stk_ovf);
        unf_d = flag_clr ? stk_unf : (unf_q | stk_unf);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= '0;
            incr_q <= A_ONE;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            incr_q <= incr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign pc        = pc_q;
    assign incr_pc   = incr_q;
    assign depth     = stk_depth;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack (ADDR_W=11, REL_W=10, DEPTH=4).
// Build with PC_CALL_STACK_ERRCLR_EN defined to also exercise err_clr.
module tb_pc_call_stack;

    logic        clock;
    logic        reset_n;
    logic        stall, preload, branch, jsr, ret;
    logic [10:0] preload_addr;
    logic [9:0]  rel_addr;
`ifdef PC_CALL_STACK_ERRCLR_EN
    logic        err_clr;
`endif
    logic [10:0] pc, incr_pc;
    logic [2:0]  depth;
    logic        overflow, underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        logic        s, p;
        logic [10:0] pa;
        logic        j, r, b;
        logic [9:0]  rel;
        logic [10:0] epc;
        logic [2:0]  ed;
        logic        eo, eu;
    } cmd_t;

    cmd_t exp_q[$];

    pc_call_stack #(.ADDR_W(11), .REL_W(10), .DEPTH(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall        (stall),
        .preload      (preload),
        .preload_addr (preload_addr),
        .branch       (branch),
        .jsr          (jsr),
        .ret          (ret),
        .rel_addr     (rel_addr),
`ifdef PC_CALL_STACK_ERRCLR_EN
        .err_clr      (err_clr),
`endif
        .pc           (pc),
        .incr_pc      (incr_pc),
        .depth        (depth),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic cmd_t mk(input string nm, input logic s, input logic p,
                                input logic [10:0] pa, input logic j, input logic r,
                                input logic b, input logic [9:0] rel,
                                input logic [10:0] epc, input logic [2:0] ed,
                                input logic eo, input logic eu);
        cmd_t c;
        c.nm = nm; c.s = s; c.p = p; c.pa = pa; c.j = j; c.r = r; c.b = b;
        c.rel = rel; c.epc = epc; c.ed = ed; c.eo = eo; c.eu = eu;
        return c;
    endfunction

    task automatic apply(input cmd_t c);
        stall = c.s; preload = c.p; preload_addr = c.pa;
        jsr = c.j; ret = c.r; branch = c.b; rel_addr = c.rel;
        exp_q.push_back(c);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; preload = 0; preload_addr = '0; jsr = 0; ret = 0; branch = 0; rel_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (pc !== 11'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", pc); end
        checks++; if (incr_pc !== 11'h001) begin failures++; $display("FAIL reset_incr got=%h exp=001", incr_pc); end
        checks++; if (depth !== 3'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_unf got=%b exp=0", underflow); end
        reset_n = 1'b1;
    endtask

    task automatic test_idle_and_wrap();
        cmd_t t[$];
        cmd_t e;
        logic [10:0] ei;
        for (int k = 1; k <= 5; k++) t.push_back(mk("idle", 0,0,0, 0,0,0, 0, 11'(k), 0,0,0));
        t.push_back(mk("wrap_load", 0,1,11'h7FE, 0,0,0, 0, 11'h7FE, 0,0,0));
        t.push_back(mk("wrap_1",    0,0,0,       0,0,0, 0, 11'h7FF, 0,0,0));
        t.push_back(mk("wrap_2",    0,0,0,       0,0,0, 0, 11'h000, 0,0,0));
        t.push_back(mk("wrap_3",    0,0,0,       0,0,0, 0, 11'h001, 0,0,0));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            ei = e.epc + 11'd1;
            checks++; if (pc !== e.epc) begin failures++; $display("FAIL %s pc got=%h exp=%h", e.nm, pc, e.epc); end
            checks++; if (incr_pc !== ei) begin failures++; $display("FAIL %s incr got=%h exp=%h", e.nm, incr_pc, ei); end
            checks++; if (depth !== e.ed) begin failures++; $display("FAIL %s depth got=%0d exp=%0d", e.nm, depth, e.ed); end
            checks++; if ({overflow, underflow} !== {e.eo, e.eu}) begin failures++; $display("FAIL %s flags got=%b%b exp=%b%b", e.nm, overflow, underflow, e.eo, e.eu); end
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        cmd_t t[$];
        cmd_t e;
        logic [10:0] ei;
        t.push_back(mk("br_load", 0,1,11'h100, 0,0,0, 10'h000, 11'h100, 0,0,0));
        t.push_back(mk("br_neg",  0,0,0,       0,0,1, 10'h3F0, 11'h0F0, 0,0,0));
        t.push_back(mk("br_pos",  0,0,0,       0,0,1, 10'h005, 11'h0F5, 0,0,0));
        t.push_back(mk("br_zero", 0,0,0,       0,0,1, 10'h000, 11'h0F5, 0,0,0));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            ei = e.epc + 11'd1;
            checks++; if (pc !== e.epc) begin failures++; $display("FAIL %s pc got=%h exp=%h", e.nm, pc, e.epc); end
            checks++; if (incr_pc !== ei) begin failures++; $display("FAIL %s incr got=%h exp=%h", e.nm, incr_pc, ei); end
            checks++; if (depth !== e.ed) begin failures++; $display("FAIL %s depth got=%0d exp=%0d", e.nm, depth, e.ed); end
        end
        idle_inputs();
    endtask

    task automatic test_nested();
        cmd_t t[$];
        cmd_t e;
        logic [10:0] ei;
        t.push_back(mk("nest_load", 0,1,11'h010, 0,0,0, 10'h000, 11'h010, 0,0,0));
        t.push_back(mk("nest_jsr1", 0,0,0,       1,0,0, 10'h020, 11'h030, 1,0,0));
        t.push_back(mk("nest_jsr2", 0,0,0,       1,0,0, 10'h010, 11'h040, 2,0,0));
        t.push_back(mk("nest_ret1", 0,0,0,       0,1,0, 10'h000, 11'h031, 1,0,0));
        t.push_back(mk("nest_ret2", 0,0,0,       0,1,0, 10'h000, 11'h011, 0,0,0));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            ei = e.epc + 11'd1;
            checks++; if (pc !== e.epc) begin failures++; $display("FAIL %s pc got=%h exp=%h", e.nm, pc, e.epc); end
            checks++; if (incr_pc !== ei) begin failures++; $display("FAIL %s incr got=%h exp=%h", e.nm, incr_pc, ei); end
            checks++; if (depth !== e.ed) begin failures++; $display("FAIL %s depth got=%0d exp=%0d", e.nm, depth, e.ed); end
            checks++; if ({overflow, underflow} !== {e.eo, e.eu}) begin failures++; $display("FAIL %s flags got=%b%b exp=%b%b", e.nm, overflow, underflow, e.eo, e.eu); end
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        cmd_t t[$];
        cmd_t e;
        logic [10:0] ei;
        t.push_back(mk("ovf_load", 0,1,11'h000, 0,0,0, 10'h000, 11'h000, 0,0,0));
        t.push_back(mk("ovf_jsr1", 0,0,0, 1,0,0, 10'h010, 11'h010, 1,0,0));
        t.push_back(mk("ovf_jsr2", 0,0,0, 1,0,0, 10'h010, 11'h020, 2,0,0));
        t.push_back(mk("ovf_jsr3", 0,0,0, 1,0,0, 10'h010, 11'h030, 3,0,0));
        t.push_back(mk("ovf_jsr4", 0,0,0, 1,0,0, 10'h010, 11'h040, 4,0,0));
        t.push_back(mk("ovf_jsr5", 0,0,0, 1,0,0, 10'h010, 11'h050, 4,1,0));
        t.push_back(mk("ovf_ret1", 0,0,0, 0,1,0, 10'h000, 11'h041, 3,1,0));
        t.push_back(mk("ovf_ret2", 0,0,0, 0,1,0, 10'h000, 11'h031, 2,1,0));
        t.push_back(mk("ovf_ret3", 0,0,0, 0,1,0, 10'h000, 11'h021, 1,1,0));
        t.push_back(mk("ovf_ret4", 0,0,0, 0,1,0, 10'h000, 11'h011, 0,1,0));
        t.push_back(mk("unf_ret5", 0,0,0, 0,1,0, 10'h000, 11'h012, 0,1,1));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            ei = e.epc + 11'd1;
            checks++; if (pc !== e.epc) begin failures++; $display("FAIL %s pc got=%h exp=%h", e.nm, pc, e.epc); end
            checks++; if (incr_pc !== ei) begin failures++; $display("FAIL %s incr got=%h exp=%h", e.nm, incr_pc, ei); end
            checks++; if (depth !== e.ed) begin failures++; $display("FAIL %s depth got=%0d exp=%0d", e.nm, depth, e.ed); end
            checks++; if ({overflow, underflow} !== {e.eo, e.eu}) begin failures++; $display("FAIL %s flags got=%b%b exp=%b%b", e.nm, overflow, underflow, e.eo, e.eu); end
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        cmd_t t[$];
        cmd_t e;
        logic [10:0] ei;
        t.push_back(mk("pri_load_jsr",  0,1,11'h200, 1,0,0, 10'h004, 11'h200, 0,1,1));
        t.push_back(mk("pri_jsr",       0,0,0,       1,0,0, 10'h004, 11'h204, 1,1,1));
        t.push_back(mk("pri_jsr_ret",   0,0,0,       1,1,0, 10'h008, 11'h20C, 2,1,1));
        t.push_back(mk("pri_ret_br",    0,0,0,       0,1,1, 10'h3FF, 11'h205, 1,1,1));
        t.push_back(mk("stall_jsr",     1,0,0,       1,0,0, 10'h010, 11'h205, 1,1,1));
        t.push_back(mk("stall_load",    1,1,11'h123, 0,0,0, 10'h000, 11'h205, 1,1,1));
        t.push_back(mk("stall_ret",     1,0,0,       0,1,0, 10'h000, 11'h205, 1,1,1));
        t.push_back(mk("pri_br_m1",     0,0,0,       0,0,1, 10'h3FF, 11'h204, 1,1,1));
        t.push_back(mk("pri_ret_last",  0,0,0,       0,1,0, 10'h000, 11'h201, 0,1,1));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            ei = e.epc + 11'd1;
            checks++; if (pc !== e.epc) begin failures++; $display("FAIL %s pc got=%h exp=%h", e.nm, pc, e.epc); end
            checks++; if (incr_pc !== ei) begin failures++; $display("FAIL %s incr got=%h exp=%h", e.nm, incr_pc, ei); end
            checks++; if (depth !== e.ed) begin failures++; $display("FAIL %s depth got=%0d exp=%0d", e.nm, depth, e.ed); end
            checks++; if ({overflow, underflow} !== {e.eo, e.eu}) begin failures++; $display("FAIL %s flags got=%b%b exp=%b%b", e.nm, overflow, underflow, e.eo, e.eu); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midcall();
        cmd_t t[$];
        cmd_t e;
        logic [10:0] ei;
        apply(mk("mid_load", 0,1,11'h300, 0,0,0, 10'h000, 11'h300, 0,1,1));
        void'(exp_q.pop_front());
        apply(mk("mid_jsr",  0,0,0,       1,0,0, 10'h010, 11'h310, 1,1,1));
        e = exp_q.pop_front();
        checks++; if (depth !== e.ed) begin failures++; $display("FAIL %s depth got=%0d exp=%0d", e.nm, depth, e.ed); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (pc !== 11'h000) begin failures++; $display("FAIL midrst_pc got=%h exp=000", pc); end
        checks++; if (incr_pc !== 11'h001) begin failures++; $display("FAIL midrst_incr got=%h exp=001", incr_pc); end
        checks++; if (depth !== 3'd0) begin failures++; $display("FAIL midrst_depth got=%0d exp=0", depth); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL midrst_flags got=%b%b exp=00", overflow, underflow); end
        reset_n = 1'b1;
        idle_inputs();
        t.push_back(mk("post_idle", 0,0,0, 0,0,0, 10'h000, 11'h001, 0,0,0));
        t.push_back(mk("post_unf",  0,0,0, 0,1,0, 10'h000, 11'h002, 0,0,1));
        t.push_back(mk("post_jsrm", 0,0,0, 1,0,0, 10'h3FE, 11'h000, 1,0,1));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            ei = e.epc + 11'd1;
            checks++; if (pc !== e.epc) begin failures++; $display("FAIL %s pc got=%h exp=%h", e.nm, pc, e.epc); end
            checks++; if (incr_pc !== ei) begin failures++; $display("FAIL %s incr got=%h exp=%h", e.nm, incr_pc, ei); end
            checks++; if (depth !== e.ed) begin failures++; $display("FAIL %s depth got=%0d exp=%0d", e.nm, depth, e.ed); end
            checks++; if ({overflow, underflow} !== {e.eo, e.eu}) begin failures++; $display("FAIL %s flags got=%b%b exp=%b%b", e.nm, overflow, underflow, e.eo, e.eu); end
        end
        idle_inputs();
    endtask

`ifdef PC_CALL_STACK_ERRCLR_EN
    task automatic test_errclr();
        cmd_t t[$];
        logic ec[$];
        cmd_t e;
        t.push_back(mk("clr_only",  0,0,0, 0,0,0, 10'h000, 11'h001, 1,0,0)); ec.push_back(1'b1);
        t.push_back(mk("clr_pop",   0,0,0, 0,1,0, 10'h000, 11'h003, 0,0,0)); ec.push_back(1'b0);
        t.push_back(mk("clr_newerr",0,0,0, 0,1,0, 10'h000, 11'h004, 0,0,1)); ec.push_back(1'b1);
        t.push_back(mk("clr_again", 0,0,0, 0,0,0, 10'h000, 11'h005, 0,0,0)); ec.push_back(1'b1);
        foreach (t[i]) begin
            err_clr = ec[i];
            apply(t[i]);
            e = exp_q.pop_front();
            checks++; if (pc !== e.epc) begin failures++; $display("FAIL %s pc got=%h exp=%h", e.nm, pc, e.epc); end
            checks++; if (depth !== e.ed) begin failures++; $display("FAIL %s depth got=%0d exp=%0d", e.nm, depth, e.ed); end
            checks++; if ({overflow, underflow} !== {e.eo, e.eu}) begin failures++; $display("FAIL %s flags got=%b%b exp=%b%b", e.nm, overflow, underflow, e.eo, e.eu); end
        end
        err_clr = 1'b0;
        idle_inputs();
    endtask
`endif

    initial begin
`ifdef PC_CALL_STACK_ERRCLR_EN
        err_clr = 1'b0;
`endif
        test_reset();
        test_idle_and_wrap();
        test_branch();
        test_nested();
        test_overflow();
        test_priority();
        test_reset_midcall();
`ifdef PC_CALL_STACK_ERRCLR_EN
        test_errclr();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
